detector_secuencia_param: RTL and testbench
===========================================

# detector_secuencia_param

Parametrised serial sequence detector, successor to the fixed `1101` detector. Samples one serial bit per qualified clock edge, compares the last `ANCHO` bits against a runtime-loadable pattern, and raises a one-cycle detection pulse. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits between the serial input conditioning and the status/readout logic in the detector chain.

## Interface
- `ANCHO`, 4: pattern length in bits, 2..16.
- `PATRON_INI`, 4'b1101: pattern after reset, `ANCHO` bits wide, MSB = oldest bit.
- `ANCHO_CNT`, 8: width of the match counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous reset, active-low; asserts immediately, deasserts synchronously to `clk` externally.
- `dato` in 1: serial data bit.
- `valido` in 1: `dato` is sampled only on edges where `valido`=1.
- `solapamiento` in 1: 1 = overlapping matches, 0 = non-overlapping; sampled every edge.
- `cargar` in 1: load `patron_in` as the new pattern.
- `patron_in` in `ANCHO`: new pattern, MSB = oldest bit.
- `borrar_cuenta` in 1: clear match counter.
- `detectada` out 1: registered one-cycle match pulse.
- `cuenta` out `ANCHO_CNT`: saturating number of matches.
- `patron` out `ANCHO`: currently active pattern.

## Operation
- Registers: window `ventana[ANCHO-1:0]`, fill count `llenos` (0..`ANCHO`), `patron`, `cuenta`, `detectada`.
- FSM derived from `llenos`: VACIO (0) -> LLENANDO (1..`ANCHO`-1) -> ARMADO (`ANCHO`). Each valid sample advances one step; ARMADO is held until a non-overlapping match or a load.
- Valid sample: `ventana_n = {ventana[ANCHO-2:0], dato}`; `llenos_n = min(llenos+1, ANCHO)`.
- Match is `llenos_n == ANCHO && ventana_n == patron`. A match sets `detectada`=1 for exactly one cycle.
- On a match with `solapamiento`=0, `llenos` returns to 0 (VACIO), so no bit is reused. With `solapamiento`=1, `llenos` stays at `ANCHO`.
- Edges with `valido`=0 leave the window, fill count and FSM unchanged; `detectada`=0.
- `cargar`=1: `patron<=patron_in`, `ventana<=0`, `llenos<=0`, `detectada<=0`. `cargar` wins over `valido` in the same edge, and that sample is discarded.
- `cuenta` increments on each match and saturates at 2^`ANCHO_CNT`-1 with no wrap.
- `borrar_cuenta` with a simultaneous match gives `cuenta`=1. `borrar_cuenta` alone gives 0.
- `cargar` does not clear `cuenta`.

## Timing
- Reset values: `detectada`=0, `cuenta`=0, `patron`=`PATRON_INI`, `ventana`=0, `llenos`=0.
- Latency: `detectada` rises on the same edge that samples the completing bit, so it is visible for the following cycle. There is no combinational path from input to output.
- Back-to-back overlapping matches may produce `detectada` on consecutive valid edges.
- Reset asserted mid-sequence: all partial progress is lost immediately. After release, at least `ANCHO` valid samples are required before a match.
- `patron` output updates on the edge after `cargar`.

## Structure
- Package `detector_pkg` holds:
  - default pattern constant `PATRON_DEF` = 4'b1101;
  - the FSM state encoding (VACIO/LLENANDO/ARMADO);
  - the fill-counter width function `clog2(ANCHO+1)`.
- One sub-module, `ventana_desplazamiento`: shift register plus fill counter, with inputs `valido`, `dato`, `limpiar` and outputs `ventana`, `llenos`.
- Top level holds the comparator, the pattern register, the counter and the output register.

## Test plan
- Reset, then `solapamiento`=1, `valido`=1, stream `1101101011101` -> `detectada` pulses after bits 4, 7 and 13; `cuenta`=3.
- Same stream with `solapamiento`=0 -> pulses after bits 4 and 13 only; `cuenta`=2.
- `cargar` with `patron_in`=4'b0110, then stream `0110110` (overlap) -> pulses after bits 4 and 7. Pulsing `cargar` mid-stream with `valido`=1 discards that bit and restarts the fill.
- Gaps with `valido`=0 inserted inside `1101` -> exactly one pulse, delayed accordingly; no pulse on invalid edges.
- `ANCHO_CNT`=2 with 5 matches -> `cuenta` holds at 3. `borrar_cuenta` on a match edge -> `cuenta`=1.
- `reset` asserted asynchronously after `110`, released, then `1` -> no pulse; `cuenta`=0, `patron`=4'b1101.

Source files
------------

// File: rtl/detector_pkg.sv
`default_nettype none
// ============================================================================
// detector_pkg: shared constants, FSM encoding and width helper for the
// parametrised sequence detector.                                   Rev 1.0
// ============================================================================
package detector_pkg;

    localparam logic [3:0] PATRON_DEF = 4'b1101;

    typedef logic [1:0] estado_t;
    localparam estado_t VACIO    = 2'd0;
    localparam estado_t LLENANDO = 2'd1;
    localparam estado_t ARMADO   = 2'd2;

    // Fill counter must represent 0..ancho inclusive.
    function automatic int ancho_llenos(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/detector_secuencia_param_if.sv
`default_nettype none
// ============================================================================
// detector_secuencia_param_if: data/control/status bundle of the detector.
//                                                                   Rev 1.0
// ============================================================================
interface detector_secuencia_param_if #(
    parameter int ANCHO     = 4,
    parameter int ANCHO_CNT = 8
);
    logic                 dato;
    logic                 valido;
    logic                 solapamiento;
    logic                 cargar;
    logic [ANCHO-1:0]     patron_in;
    logic                 borrar_cuenta;
    logic                 detectada;
    logic [ANCHO_CNT-1:0] cuenta;
    logic [ANCHO-1:0]     patron;

    modport master (
        output dato, valido, solapamiento, cargar, patron_in, borrar_cuenta,
        input  detectada, cuenta, patron
    );

    modport slave (
        input  dato, valido, solapamiento, cargar, patron_in, borrar_cuenta,
        output detectada, cuenta, patron
    );
endinterface
`default_nettype wire

// File: rtl/ventana_desplazamiento.sv
`default_nettype none
// ============================================================================
// ventana_desplazamiento: serial shift window plus saturating fill counter.
//                                                                   Rev 1.0
// ============================================================================
module ventana_desplazamiento
    import detector_pkg::*;
#(
    parameter int ANCHO    = 4,
    parameter int LLENOS_W = ancho_llenos(ANCHO)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valido,
    input  logic                dato,
    input  logic                limpiar,
    output logic [ANCHO-1:0]    ventana,
    output logic [LLENOS_W-1:0] llenos
);

    // limpiar has priority so a load or non-overlapping match discards the bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ventana <= '0;
            llenos  <= '0;
        end else if (limpiar) begin
            ventana <= '0;
            llenos  <= '0;
        end else if (valido) begin
            ventana <= {ventana[ANCHO-2:0], dato};
            if (llenos != LLENOS_W'(ANCHO))
                llenos <= llenos + LLENOS_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/detector_secuencia_param.sv
`default_nettype none
// ============================================================================
// detector_secuencia_param: runtime-loadable serial pattern detector with
// overlap control and saturating match counter.                     Rev 1.0
// ============================================================================
module detector_secuencia_param
    import detector_pkg::*;
#(
    parameter int               ANCHO      = 4,
    parameter logic [ANCHO-1:0] PATRON_INI = PATRON_DEF,
    parameter int               ANCHO_CNT  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    detector_secuencia_param_if.slave   bus
);

    localparam int                   LLENOS_W   = ancho_llenos(ANCHO);
    localparam logic [ANCHO_CNT-1:0] CUENTA_MAX = '1;

    logic [ANCHO-1:0]     ventana;
    logic [ANCHO-1:0]     ventana_sig;
    logic [LLENOS_W-1:0]  llenos;
    logic [ANCHO-1:0]     patron_act;
    logic [ANCHO_CNT-1:0] cuenta_act;
    logic                 detectada_act;
    logic                 lleno_sig;
    logic                 coincide;
    logic                 limpiar;
    estado_t              estado;
    estado_t              estado_sig;

    ventana_desplazamiento #(
        .ANCHO    (ANCHO),
        .LLENOS_W (LLENOS_W)
    ) u_ventana (
        .clk     (clk),
        .reset   (reset),
        .valido  (bus.valido),
        .dato    (bus.dato),
        .limpiar (limpiar),
        .ventana (ventana),
        .llenos  (llenos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= VACIO;
        else
            estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        if (bus.cargar) begin
            estado_sig = VACIO;
        end else if (bus.valido) begin
            if (coincide && !bus.solapamiento)
                estado_sig = VACIO;
            else if (lleno_sig)
                estado_sig = ARMADO;
            else
                estado_sig = LLENANDO;
        end
    end

    // The window is full after this sample if already armed or one bit short.
    always_comb begin
        ventana_sig = {ventana[ANCHO-2:0], bus.dato};
        lleno_sig   = (estado == ARMADO) || (llenos == LLENOS_W'(ANCHO - 1));
        coincide    = bus.valido && !bus.cargar && lleno_sig
                      && (ventana_sig == patron_act);
        limpiar     = bus.cargar || (coincide && !bus.solapamiento);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            patron_act    <= PATRON_INI;
            cuenta_act    <= '0;
            detectada_act <= 1'b0;
        end else begin
            detectada_act <= coincide;
            if (bus.cargar)
                patron_act <= bus.patron_in;
            if (bus.borrar_cuenta)
                cuenta_act <= coincide ? ANCHO_CNT'(1) : '0;
            else if (coincide && cuenta_act != CUENTA_MAX)
                cuenta_act <= cuenta_act + ANCHO_CNT'(1);
        end
    end

    assign bus.detectada = detectada_act;
    assign bus.cuenta    = cuenta_act;
    assign bus.patron    = patron_act;

endmodule
`default_nettype wire

// File: tb/tb_detector_secuencia_param.sv
`default_nettype none
// ============================================================================
// tb_detector_secuencia_param: scoreboard bench, directed vectors.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_detector_secuencia_param;
    import detector_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    detector_secuencia_param_if #(.ANCHO(4), .ANCHO_CNT(8)) bus ();
    detector_secuencia_param_if #(.ANCHO(4), .ANCHO_CNT(2)) bus2 ();

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus2.dato          = bus.dato;
    assign bus2.valido        = bus.valido;
    assign bus2.solapamiento  = bus.solapamiento;
    assign bus2.cargar        = bus.cargar;
    assign bus2.patron_in     = bus.patron_in;
    assign bus2.borrar_cuenta = bus.borrar_cuenta;

    detector_secuencia_param #(.ANCHO(4), .PATRON_INI(4'b1101), .ANCHO_CNT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    detector_secuencia_param #(.ANCHO(4), .PATRON_INI(4'b1101), .ANCHO_CNT(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic       det;
        int         cnt;
        int         cnt2;
        logic [3:0] pat;
        string      nm;
    } esperado_t;

    esperado_t  sb[$];
    int         tests   = 0;
    int         fails   = 0;
    int         exp_cnt = 0;
    logic [3:0] exp_pat = PATRON_DEF;

    task automatic comparar(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // One clock of stimulus; the expected response goes to the scoreboard.
    task automatic paso(input logic d, input logic v, input logic det, input string nm,
                        input logic carga = 1'b0, input logic [3:0] pin = 4'b0000,
                        input logic borra = 1'b0);
        esperado_t e;
        @(negedge clk);
        bus.dato          = d;
        bus.valido        = v;
        bus.cargar        = carga;
        bus.patron_in     = pin;
        bus.borrar_cuenta = borra;
        if (borra)
            exp_cnt = det ? 1 : 0;
        else if (det)
            exp_cnt++;
        if (carga)
            exp_pat = pin;
        e.det  = det;
        e.cnt  = (exp_cnt > 255) ? 255 : exp_cnt;
        e.cnt2 = (exp_cnt > 3) ? 3 : exp_cnt;
        e.pat  = exp_pat;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic flujo(input string bits, input string picos, input string nm);
        for (int i = 0; i < bits.len(); i++)
            paso(bits.getc(i) == "1", 1'b1, picos.getc(i) == "1",
                 $sformatf("%s bit%0d", nm, i + 1));
    endtask

    task automatic vaciar(input string nm);
        int n;
        n = 0;
        paso(1'b0, 1'b0, 1'b0, {nm, " idle"});
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            comparar({nm, " drain timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic aplicar_reset(input string nm);
        @(negedge clk);
        reset             = 1'b0;
        bus.dato          = 1'b0;
        bus.valido        = 1'b0;
        bus.cargar        = 1'b0;
        bus.patron_in     = 4'b0000;
        bus.borrar_cuenta = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 0;
        exp_pat = PATRON_DEF;
        #1;
        comparar({nm, " detectada"},  int'(bus.detectada), 0);
        comparar({nm, " cuenta"},     int'(bus.cuenta), 0);
        comparar({nm, " cuenta_sat"}, int'(bus2.cuenta), 0);
        comparar({nm, " patron"},     int'(bus.patron), int'(exp_pat));
    endtask

    // Monitor: outputs are checked 1 ns after the edge that produced them.
    initial begin
        esperado_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                comparar({e.nm, " detectada"},  int'(bus.detectada), int'(e.det));
                comparar({e.nm, " cuenta"},     int'(bus.cuenta), e.cnt);
                comparar({e.nm, " cuenta_sat"}, int'(bus2.cuenta), e.cnt2);
                comparar({e.nm, " patron"},     int'(bus.patron), int'(e.pat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        bus.dato          = 1'b0;
        bus.valido        = 1'b0;
        bus.solapamiento  = 1'b1;
        bus.cargar        = 1'b0;
        bus.patron_in     = 4'b0000;
        bus.borrar_cuenta = 1'b0;
        repeat (2) @(negedge clk);

        aplicar_reset("reset_init");
        bus.solapamiento = 1'b1;
        flujo("1101101011101", "0001001000001", "solap");
        vaciar("solap");

        aplicar_reset("reset_t2");
        bus.solapamiento = 1'b0;
        flujo("1101101011101", "0001000000001", "nosolap");
        vaciar("nosolap");

        aplicar_reset("reset_t3");
        bus.solapamiento = 1'b1;
        paso(1'b0, 1'b0, 1'b0, "load0110", 1'b1, 4'b0110);
        flujo("0110110", "0001001", "p0110");
        flujo("011", "000", "pre_load");
        paso(1'b0, 1'b1, 1'b0, "load_mid", 1'b1, 4'b0110);
        flujo("1100110", "0000001", "post_load");
        vaciar("load");

        aplicar_reset("reset_t4");
        bus.solapamiento = 1'b1;
        paso(1'b1, 1'b1, 1'b0, "gap b1");
        paso(1'b0, 1'b0, 1'b0, "gap g1");
        paso(1'b1, 1'b1, 1'b0, "gap b2");
        paso(1'b0, 1'b0, 1'b0, "gap g2");
        paso(1'b1, 1'b0, 1'b0, "gap g3");
        paso(1'b0, 1'b1, 1'b0, "gap b3");
        paso(1'b1, 1'b0, 1'b0, "gap g4");
        paso(1'b1, 1'b1, 1'b1, "gap b4");
        paso(1'b1, 1'b0, 1'b0, "gap g5");
        paso(1'b1, 1'b0, 1'b0, "gap g6");
        vaciar("gap");

        aplicar_reset("reset_t5");
        bus.solapamiento = 1'b1;
        flujo("1101101101101101", "0001001001001001", "sat");
        paso(1'b1, 1'b1, 1'b0, "clr b1");
        paso(1'b0, 1'b1, 1'b0, "clr b2");
        paso(1'b1, 1'b1, 1'b1, "clr_on_match", 1'b0, 4'b0000, 1'b1);
        paso(1'b0, 1'b0, 1'b0, "clr_alone",    1'b0, 4'b0000, 1'b1);
        vaciar("clr");

        aplicar_reset("reset_t6");
        bus.solapamiento = 1'b1;
        flujo("1101110", "0001000", "pre_async");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        comparar("async detectada",  int'(bus.detectada), 0);
        comparar("async cuenta",     int'(bus.cuenta), 0);
        comparar("async cuenta_sat", int'(bus2.cuenta), 0);
        comparar("async patron",     int'(bus.patron), int'(PATRON_DEF));
        @(negedge clk);
        bus.valido = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 0;
        exp_pat = PATRON_DEF;
        flujo("1101", "0001", "post_async");
        vaciar("post_async");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
